// File: rtl/dmem_responder_pkg.sv
// Shared types for the handshaked data-memory responder.
package dmem_responder_pkg;

  typedef logic        Signal;
  typedef logic [31:0] Register;

  localparam int MEM_LAT_W = 4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} mem_state_t;

  typedef struct packed {
    Signal   write;
    Register addr;
    Register wdata;
  } mem_req_t;

  typedef struct packed {
    Signal   valid;
    Signal   write;
    Signal   err;
    Register rdata;
  } mem_resp_t;

  // A byte address is bad if it is not word aligned or falls past the last word.
  function automatic logic addr_err(input Register addr, input int unsigned depth);
    return (addr[1:0] != 2'b00) || ({32'b0, addr} >= (64'(depth) * 64'd4));
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage: synchronous write, registered read, contents not reset.
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  Register       wdata,
  input  logic [AW-1:0] raddr,
  output Register       rdata
);

  Register mem [DEPTH];

  // Write when enabled; always register the word at raddr.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one request in flight, LATENCY wait
// states, then a single response beat with load data or a store ack.
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready;
// req_ready is high exactly while the FSM is IDLE. The response is a one-cycle
// strobe on resp_valid with no backpressure; resp_* are all zero outside it.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  Register    req_addr,
  input  Register    req_wdata,
  output logic       resp_valid,
  output logic       resp_write,
  output Register    resp_rdata,
  output logic       resp_err,
  output mem_state_t state_dbg
);

  localparam int AW = $clog2(DEPTH);

  mem_state_t           state;
  logic [MEM_LAT_W-1:0] count;
  mem_req_t             req_q;
  logic                 resp_valid_q;
  logic                 resp_write_q;
  logic                 resp_err_q;
  logic                 resp_load_ok_q;

  mem_req_t  cur;
  logic      accept;
  logic      go_resp;
  logic      cur_err;
  logic      arr_we;
  Register   arr_rdata;
  mem_resp_t resp;

  // Accept/commit decode; with zero latency the live request commits on its accept edge.
  always_comb begin
    accept  = (state == IDLE) && req_valid;
    go_resp = (accept && (LATENCY == 0)) ||
              ((state == WAIT) && (count == MEM_LAT_W'(1)));
    cur     = (state == IDLE) ? '{write: req_write, addr: req_addr, wdata: req_wdata}
                              : req_q;
    cur_err = addr_err(cur.addr, DEPTH);
    arr_we  = go_resp && cur.write && !cur_err && !reset;
  end

  dmem_array #(.DEPTH(DEPTH)) u_array (
    .clk   (clk),
    .we    (arr_we),
    .waddr (cur.addr[AW+1:2]),
    .wdata (cur.wdata),
    .raddr (cur.addr[AW+1:2]),
    .rdata (arr_rdata)
  );

  // Request FSM, wait counter and response flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      count          <= '0;
      req_q          <= '0;
      resp_valid_q   <= 1'b0;
      resp_write_q   <= 1'b0;
      resp_err_q     <= 1'b0;
      resp_load_ok_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            req_q <= cur;
            if (LATENCY == 0) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              count <= MEM_LAT_W'(LATENCY);
            end
          end
        end
        WAIT: begin
          count <= count - 1'b1;
          if (count == MEM_LAT_W'(1)) state <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
      resp_valid_q   <= go_resp;
      resp_write_q   <= go_resp && cur.write;
      resp_err_q     <= go_resp && cur_err;
      resp_load_ok_q <= go_resp && !cur.write && !cur_err;
    end
  end

  // Response beat; load data is gated so stores, errors and idle cycles read zero.
  always_comb begin
    resp.valid = resp_valid_q;
    resp.write = resp_write_q;
    resp.err   = resp_err_q;
    resp.rdata = resp_load_ok_q ? arr_rdata : '0;
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = resp.valid;
  assign resp_write = resp.write;
  assign resp_err   = resp.err;
  assign resp_rdata = resp.rdata;
  assign state_dbg  = state;

endmodule
